// File: rtl/bus_pkg.sv
// Shared types for the bus memory target: command modes and FSM states.
package bus_pkg;

    typedef enum logic [1:0] {
        MODE_RD  = 2'b00,
        MODE_WR  = 2'b01,
        MODE_BRD = 2'b10,
        MODE_NOP = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT,
        XFER
    } state_e;

endpackage

// File: rtl/bus_mem_array.sv
// 2**AW x DW storage: synchronous write port, combinational read port, never reset.
module bus_mem_array #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata_c
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/bus_mem_target.sv
// Bus target: req/gnt handshake, start-qualified command, wait states, rdy-per-beat
// single read, single write, burst read and NOP against a local memory array.
module bus_mem_target
    import bus_pkg::*;
#(
    parameter int unsigned AW        = 8,
    parameter int unsigned DW        = 8,
    parameter int unsigned WAIT_CYC  = 2,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          gnt,
    output logic          rdy,
    output logic [DW-1:0] rdata,
    output logic          data_oe
);

    localparam int unsigned WCW = $clog2(WAIT_CYC + 2);
    localparam int unsigned BCW = $clog2(BURST_LEN + 1);

    state_e         state;
    mode_e          mode_q;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  wdata_q;
    logic [WCW-1:0] wait_cnt;
    logic [BCW-1:0] beat_cnt;
    logic [DW-1:0]  rdata_c;
    logic           we;
    logic           last_beat;

    // Write commits on the same edge that raises rdy; an async reset kills it at once.
    always_comb begin
        we        = (state == XFER) && (mode_q == MODE_WR) && !rst;
        last_beat = (mode_q != MODE_BRD) || (beat_cnt == BCW'(BURST_LEN - 1));
    end

    bus_mem_array #(
        .AW(AW),
        .DW(DW)
    ) u_mem (
        .clk    (clk),
        .we     (we),
        .waddr  (addr_q),
        .wdata  (wdata_q),
        .raddr  (addr_q),
        .rdata_c(rdata_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            rdy      <= 1'b0;
            rdata    <= '0;
            data_oe  <= 1'b0;
            mode_q   <= MODE_RD;
            addr_q   <= '0;
            wdata_q  <= '0;
            wait_cnt <= '0;
            beat_cnt <= '0;
        end else begin
            rdy     <= 1'b0;
            data_oe <= 1'b0;
            rdata   <= '0;
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= GRANT;
                        gnt   <= 1'b1;
                    end
                end
                GRANT: begin
                    if (start) begin
                        mode_q   <= mode_e'(mode);
                        addr_q   <= addr;
                        wdata_q  <= wdata;
                        wait_cnt <= WCW'(WAIT_CYC);
                        beat_cnt <= '0;
                        state    <= (WAIT_CYC == 0) ? XFER : WAIT;
                    end else if (!req) begin
                        state <= IDLE;
                        gnt   <= 1'b0;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt <= WCW'(1)) begin
                        state <= XFER;
                    end
                end
                XFER: begin
                    rdy      <= 1'b1;
                    beat_cnt <= beat_cnt + 1'b1;
                    if (mode_q == MODE_RD || mode_q == MODE_BRD) begin
                        rdata   <= rdata_c;
                        data_oe <= 1'b1;
                    end
                    if (mode_q == MODE_BRD) begin
                        addr_q <= addr_q + 1'b1;
                    end
                    if (last_beat) begin
                        state <= req ? GRANT : IDLE;
                        gnt   <= req;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 1'b0;
                end
            endcase
        end
    end

endmodule
